decoder_3_8: RTL and testbench
==============================

// Module: decoder_3_8
// PURPOSE
//   Registered 3-to-8 line decoder with enable. Converts a 3-bit binary select
//   into a one-hot 8-bit output, registered on the clock, for chip-select and
//   row-select generation. Sits between control/address logic and the block it
//   selects. It has one clock domain and no handshake back-pressure.
// PARAMETERS
//   ACTIVE_LOW_OUT  0  1 = output inverted (one-cold: selected bit 0, others 1)
// PORTS
//   clk    in   1  system clock; all state updates on rising edge
//   rst_n  in   1  reset, asynchronous assert, active-low
//   en     in   1  decode enable; when 0, no output line is selected
//   w      in   3  binary select input, 0..7
//   out    out  8  decoded output; bit k corresponds to w == k
//   valid  out  1  high when out holds a decode of an enabled input
// BEHAVIOUR
//   - One clock, one async active-low reset. rst_n = 0 forces the state
//     immediately, without waiting for a clock edge:
//     out = 8'h00 (8'hFF if ACTIVE_LOW_OUT=1), valid = 0.
//     Release is synchronised by the integrator. The first update happens on
//     the first rising clk edge with rst_n = 1.
//   - Decode function (active-high form): d[k] = en & (w == k), k = 0..7.
//     Exactly one bit of d is set when en = 1; d = 0 when en = 0.
//     The table is w=000 -> 8'b0000_0001 through w=111 -> 8'b1000_0000.
//   - Registered output: on each rising clk edge, out <= d (or ~d if
//     ACTIVE_LOW_OUT=1), and valid <= en.
//   - Latency: exactly 1 clock from the w/en sample to out/valid.
//     Throughput is 1 new decode per clock. out holds its value between edges.
//   - w may change every cycle. No glitches appear on out, because it is a
//     register output.
//   - Reset asserted mid-operation clears out/valid at once, regardless of clk.
//     A decode in flight is discarded.
//   - en deasserted: on the next edge out goes to all-inactive and valid = 0.
//     w is ignored in this state.
//   - Invariant: out (active-high view) is zero-hot or one-hot, never multi-hot.
//     valid = 1 exactly when it is one-hot.
//   - Inputs are sampled only at clk edges. No combinational path exists from
//     w/en to out.
// TESTING
//   - Reset: rst_n=0 with clk toggling -> out=8'h00, valid=0. Then assert
//     rst_n=0 between edges mid-run -> out clears without waiting for an edge.
//   - Full sweep: en=1, w=0..7, one value per clock -> 1 cycle later out =
//     01,02,04,08,10,20,40,80 (hex) and valid=1 throughout.
//   - Enable gating: en=0 with w=3'b101 -> next edge out=8'h00 and valid=0.
//     Then en=1 -> next edge out=8'h20.
//   - Back-to-back change: w=7 then w=0 on consecutive edges -> out=8'h80
//     then 8'h01, with no multi-hot value at any edge.
//   - ACTIVE_LOW_OUT=1: en=1, w=2 -> out=8'hFB. With en=0 -> out=8'hFF.
//     Reset -> out=8'hFF.
//   - Randomised run of 1000 cycles: compare against reference model
//     out == (en_d ? 1<<w_d : 0), where en_d/w_d are the values delayed by 1
//     cycle. Also check $onehot0(out) on every cycle.

Source files
------------

// File: rtl/decoder_3_8.sv
// Registered 3-to-8 line decoder with enable, for chip-select / row-select generation.
// One-hot output by default; ACTIVE_LOW_OUT=1 gives the one-cold form.
module decoder_3_8 #(
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] w,
    output logic [7:0] out,
    output logic       valid
);

    // All lines inactive: used for reset and for a disabled decode.
    localparam logic [7:0] IDLE_OUT = ACTIVE_LOW_OUT ? 8'hFF : 8'h00;

    logic [7:0] dec;

    // NOTE: dec gets a default before the conditional write so no latch is inferred.
    always_comb begin
        dec = 8'h00;
        if (en) begin
            dec[w] = 1'b1;
        end
    end

    // NOTE: non-blocking assignments keep out/valid sampling pre-edge inputs together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= IDLE_OUT;
            valid <= 1'b0;
        end else begin
            out   <= ACTIVE_LOW_OUT ? ~dec : dec;
            valid <= en;
        end
    end

endmodule

// File: tb/tb_decoder_3_8.sv
// Self-checking bench for decoder_3_8: one active-high and one active-low instance
// driven by the same stimulus, checked against hand-computed vectors and a reference model.
module tb_decoder_3_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] w;
    logic [7:0] out_hi;
    logic       valid_hi;
    logic [7:0] out_lo;
    logic       valid_lo;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_3_8 #(.ACTIVE_LOW_OUT(1'b0)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .w     (w),
        .out   (out_hi),
        .valid (valid_hi)
    );

    decoder_3_8 #(.ACTIVE_LOW_OUT(1'b1)) dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .w     (w),
        .out   (out_lo),
        .valid (valid_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] w;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both instances against one active-high expectation.
    task automatic check_both(input string name, input logic [7:0] exp_out, input logic exp_valid);
        check({name, " out_hi"},   out_hi,          exp_out);
        check({name, " out_lo"},   out_lo,          ~exp_out);
        check({name, " valid_hi"}, {7'd0, valid_hi}, {7'd0, exp_valid});
        check({name, " valid_lo"}, {7'd0, valid_lo}, {7'd0, exp_valid});
        check({name, " onehot0"},  {7'd0, $onehot0(out_hi)}, 8'd1);
    endtask

    initial begin
        // Full sweep, then enable gating and back-to-back corner cases.
        vecs[0]  = '{1'b1, 3'd0, 8'h01};
        vecs[1]  = '{1'b1, 3'd1, 8'h02};
        vecs[2]  = '{1'b1, 3'd2, 8'h04};
        vecs[3]  = '{1'b1, 3'd3, 8'h08};
        vecs[4]  = '{1'b1, 3'd4, 8'h10};
        vecs[5]  = '{1'b1, 3'd5, 8'h20};
        vecs[6]  = '{1'b1, 3'd6, 8'h40};
        vecs[7]  = '{1'b1, 3'd7, 8'h80};
        vecs[8]  = '{1'b0, 3'd5, 8'h00};
        vecs[9]  = '{1'b1, 3'd5, 8'h20};
        vecs[10] = '{1'b1, 3'd7, 8'h80};
        vecs[11] = '{1'b1, 3'd0, 8'h01};
        vecs[12] = '{1'b0, 3'd7, 8'h00};
        vecs[13] = '{1'b1, 3'd2, 8'h04};

        // Reset held with the clock running and inputs requesting a decode.
        rst_n = 1'b0;
        en    = 1'b1;
        w     = 3'd3;
        tick();
        tick();
        check_both("reset", 8'h00, 1'b0);

        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            en = vecs[i].en;
            w  = vecs[i].w;
            tick();
            check_both($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].en);
        end

        // Output holds between edges.
        #3;
        check_both("hold", 8'h04, 1'b1);

        // Mid-run asynchronous reset: clears before the next edge.
        en = 1'b1;
        w  = 3'd6;
        tick();
        check_both("pre_async", 8'h40, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_both("async_reset", 8'h00, 1'b0);
        tick();
        check_both("reset_hold", 8'h00, 1'b0);
        rst_n = 1'b1;
        w     = 3'd1;
        tick();
        check_both("post_reset", 8'h02, 1'b1);

        // Randomised run against a reference model.
        for (int c = 0; c < 1000; c++) begin
            logic       en_d;
            logic [2:0] w_d;
            logic [7:0] exp_out;
            en_d = 1'($urandom_range(0, 3) != 0);
            w_d  = 3'($urandom_range(0, 7));
            en   = en_d;
            w    = w_d;
            tick();
            exp_out = en_d ? (8'h01 << w_d) : 8'h00;
            check_both("random", exp_out, en_d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
